// File: rtl/exp_alu_datapath_if.sv
// Control/data bundle for the exponent datapath: operands, ALU controls, registered result.
// Flag outputs exist only when SMALLALU_FLAGS_EN is defined.
interface exp_alu_datapath_if;
  logic [7:0] valor1;
  logic [7:0] valor2;
  logic [3:0] ALUOp;
  logic       muxA;
  logic       muxB;
  logic       loadReg;
  logic [7:0] result;
`ifdef SMALLALU_FLAGS_EN
  logic       zero;
  logic       exp_ovf;
`endif

  modport master (
    output valor1, valor2, ALUOp, muxA, muxB, loadReg,
`ifdef SMALLALU_FLAGS_EN
    input  zero, exp_ovf,
`endif
    input  result
  );

  modport slave (
    input  valor1, valor2, ALUOp, muxA, muxB, loadReg,
`ifdef SMALLALU_FLAGS_EN
    output zero, exp_ovf,
`endif
    output result
  );
endinterface

// File: rtl/exp_alu_datapath.sv
// 8-bit exponent datapath: two 64-bit operand muxes, a 64-bit ALU and a loadable result register.
// Optional registered zero/exp_ovf flags are enabled by defining SMALLALU_FLAGS_EN.

module mux_2x1_64bit #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  output logic [WIDTH-1:0] X
);
  assign X = S ? B : A;
endmodule

module ALU #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] Y
);
  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  logic           lt_signed;
  logic           lt_unsigned;

  assign shamt       = B[SHW-1:0];
  assign lt_signed   = $signed(A) < $signed(B);
  assign lt_unsigned = A < B;

  // Undefined opcodes deliberately yield zero rather than holding any previous value.
  always_comb begin
    Y = '0;
    case (ALUOp)
      4'b0000: Y = A + B;
      4'b0001: Y = A << shamt;
      4'b0010: Y = {{(WIDTH-1){1'b0}}, lt_signed};
      4'b0011: Y = A - B;
      4'b0100: Y = A ^ B;
      4'b0101: Y = A >> shamt;
      4'b0110: Y = A | B;
      4'b0111: Y = A & B;
      4'b1000: Y = $signed(A) >>> shamt;
      4'b1001: Y = {{(WIDTH-1){1'b0}}, lt_unsigned};
      default: Y = '0;
    endcase
  end
endmodule

module reg_parametrizado_64b #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end
endmodule

module exp_alu_datapath #(
  parameter logic [7:0] BIAS  = 8'd127,
  parameter int         WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  exp_alu_datapath_if.slave     bus
);
  logic [WIDTH-1:0] ext_valor1;
  logic [WIDTH-1:0] ext_valor2;
  logic [WIDTH-1:0] ext_bias;
  logic [WIDTH-1:0] mux_a_out;
  logic [WIDTH-1:0] mux_b_out;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] reg_q;

  assign ext_valor1 = {{(WIDTH-8){1'b0}}, bus.valor1};
  assign ext_valor2 = {{(WIDTH-8){1'b0}}, bus.valor2};
  assign ext_bias   = {{(WIDTH-8){1'b0}}, BIAS};

  // Mux A feeds ALU operand B (subtrahend), mux B feeds operand A, so SUB computes valor2 - valor1.
  mux_2x1_64bit #(.WIDTH(WIDTH)) u_mux_a (
    .A (ext_valor1),
    .B (ext_bias),
    .S (bus.muxA),
    .X (mux_a_out)
  );

  mux_2x1_64bit #(.WIDTH(WIDTH)) u_mux_b (
    .A (ext_valor2),
    .B (reg_q),
    .S (bus.muxB),
    .X (mux_b_out)
  );

  ALU #(.WIDTH(WIDTH)) u_alu (
    .A     (mux_b_out),
    .B     (mux_a_out),
    .ALUOp (bus.ALUOp),
    .Y     (alu_out)
  );

  reg_parametrizado_64b #(.WIDTH(WIDTH)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (bus.loadReg),
    .d     (alu_out),
    .q     (reg_q)
  );

  assign bus.result = reg_q[7:0];

`ifdef SMALLALU_FLAGS_EN
  logic zero_q;
  logic ovf_q;

  // Flags track the value being loaded so they always describe the current register contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.loadReg) begin
      zero_q <= (alu_out == '0);
      ovf_q  <= |alu_out[WIDTH-1:8];
    end
  end

  assign bus.zero    = zero_q;
  assign bus.exp_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_exp_alu_datapath.sv
// Directed, table-driven bench for exp_alu_datapath with hand-computed expectations
// plus hand-written async-reset sequences.
module tb_exp_alu_datapath;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exp_alu_datapath_if bus ();

  exp_alu_datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic [7:0] v1;
    logic [7:0] v2;
    logic [3:0] op;
    logic       ma;
    logic       mb;
    logic       ld;
    logic [7:0] res;
    logic       z;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [7:0] v1, logic [7:0] v2, logic [3:0] op,
                              logic ma, logic mb, logic ld, logic [7:0] res, logic z, logic ovf);
    vec_t v;
    v.name = name; v.v1 = v1; v.v2 = v2; v.op = op;
    v.ma = ma; v.mb = mb; v.ld = ld;
    v.res = res; v.z = z; v.ovf = ovf;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [7:0] res, logic z, logic ovf);
    total++;
    if (bus.result !== res) begin
      bad++;
      $display("[TB] FAIL %s result got=%02h want=%02h", name, bus.result, res);
    end
`ifdef SMALLALU_FLAGS_EN
    total++;
    if (bus.zero !== z || bus.exp_ovf !== ovf) begin
      bad++;
      $display("[TB] FAIL %s flags got z=%b ovf=%b want z=%b ovf=%b",
               name, bus.zero, bus.exp_ovf, z, ovf);
    end
`else
    if (z === 1'bx || ovf === 1'bx) $display("[TB] note: unknown flag expectation in %s", name);
`endif
  endtask

  task automatic drive(logic [7:0] v1, logic [7:0] v2, logic [3:0] op,
                       logic ma, logic mb, logic ld);
    bus.valor1 = v1; bus.valor2 = v2; bus.ALUOp = op;
    bus.muxA = ma; bus.muxB = mb; bus.loadReg = ld;
  endtask

  task automatic applyStimulus(vec_t v);
    drive(v.v1, v.v2, v.op, v.ma, v.mb, v.ld);
    @(posedge clk);
    #1;
    checkOutput(v.name, v.res, v.z, v.ovf);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //             name        v1     v2     op    ma mb ld res    z  ovf
    vecs.push_back(mk("add",      8'd5,   8'd3,   4'h0, 0, 0, 1, 8'h08, 0, 0));
    vecs.push_back(mk("sub",      8'd3,   8'd10,  4'h3, 0, 0, 1, 8'h07, 0, 0));
    vecs.push_back(mk("sub_neg",  8'd5,   8'd3,   4'h3, 0, 0, 1, 8'hFE, 0, 1));
    vecs.push_back(mk("mul_e1",   8'd130, 8'd129, 4'h0, 0, 0, 1, 8'h03, 0, 1));
    vecs.push_back(mk("mul_e2",   8'd130, 8'd129, 4'h3, 1, 1, 1, 8'h84, 0, 0));
    vecs.push_back(mk("hold",     8'd7,   8'd9,   4'h0, 0, 0, 0, 8'h84, 0, 0));
    vecs.push_back(mk("and",      8'h3C,  8'hF0,  4'h7, 0, 0, 1, 8'h30, 0, 0));
    vecs.push_back(mk("or",       8'h3C,  8'hF0,  4'h6, 0, 0, 1, 8'hFC, 0, 0));
    vecs.push_back(mk("xor",      8'h3C,  8'hF0,  4'h4, 0, 0, 1, 8'hCC, 0, 0));
    vecs.push_back(mk("bad_op",   8'h3C,  8'hF0,  4'hF, 0, 0, 1, 8'h00, 1, 0));
    vecs.push_back(mk("sll",      8'd4,   8'd1,   4'h1, 0, 0, 1, 8'h10, 0, 0));
    vecs.push_back(mk("srl",      8'd3,   8'h80,  4'h5, 0, 0, 1, 8'h10, 0, 0));
    vecs.push_back(mk("slt",      8'd5,   8'd3,   4'h2, 0, 0, 1, 8'h01, 0, 0));
    vecs.push_back(mk("sltu",     8'd3,   8'd5,   4'h9, 0, 0, 1, 8'h00, 1, 0));
    vecs.push_back(mk("neg1",     8'd1,   8'd0,   4'h3, 0, 0, 1, 8'hFF, 0, 1));
    vecs.push_back(mk("sra_fb",   8'd4,   8'd0,   4'h8, 0, 1, 1, 8'hFF, 0, 1));
    vecs.push_back(mk("srl_fb",   8'd60,  8'd0,   4'h5, 0, 1, 1, 8'h0F, 0, 0));
    vecs.push_back(mk("neg2",     8'd1,   8'd0,   4'h3, 0, 0, 1, 8'hFF, 0, 1));
    vecs.push_back(mk("slt_fb",   8'd0,   8'd0,   4'h2, 0, 1, 1, 8'h01, 0, 0));
    vecs.push_back(mk("neg3",     8'd1,   8'd0,   4'h3, 0, 0, 1, 8'hFF, 0, 1));
    vecs.push_back(mk("sltu_fb",  8'd0,   8'd0,   4'h9, 0, 1, 1, 8'h00, 1, 0));
    vecs.push_back(mk("sum259",   8'd130, 8'd129, 4'h0, 0, 0, 1, 8'h03, 0, 1));
    vecs.push_back(mk("add_fb",   8'd0,   8'd0,   4'h0, 0, 1, 1, 8'h03, 0, 1));

    // Reset held with loadReg=1 and clock running: result must stay 0.
    rst_n = 1'b0;
    drive(8'd5, 8'd3, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold", 8'h00, 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Async reset between edges clears the register without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", 8'h00, 1'b0, 1'b0);

    // Aborted multiply: second step now starts from 0, giving 0 - 127.
    drive(8'd130, 8'd129, 4'h3, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_mul", 8'h81, 1'b0, 1'b1);

    // Hold with changing inputs keeps the aborted-multiply value.
    drive(8'd1, 8'd2, 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(8'd9, 8'd200, 4'h6, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("hold2", 8'h81, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
